seq_scan_ctrl: RTL and testbench
================================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 The block SHALL take parameter CNT_W, default 8, which is the width of match_count.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset sampled on the rising edge of clock.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a frame scan; it is sampled only in IDLE.
REQ-005 The block SHALL have port frame_len, input, 8 bits, the number of bytes in the frame; it is latched when start is accepted.
REQ-006 The block SHALL have port data_in, input, 8 bits, the byte to scan; bit 7 is serialized first.
REQ-007 The block SHALL have port data_valid, input, 1 bit, indicating data_in holds a valid byte.
REQ-008 The block SHALL have port data_ready, output, 1 bit, high only in LOAD.
REQ-009 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking the end of a frame.
REQ-011 The block SHALL have port match_count, output, CNT_W bits, the number of "101" detections in the last frame.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT and DONE.
REQ-013 In IDLE, if start=1 and frame_len=0, the FSM SHALL go to DONE with match_count=0.
REQ-014 In IDLE, if start=1 and frame_len>0, the FSM SHALL go to LOAD, clear match_count, set the detector to S0 and latch bytes_left=frame_len.
REQ-015 In IDLE with start=0, the FSM SHALL stay in IDLE; start SHALL be ignored in all other states.
REQ-016 In LOAD, the handshake SHALL complete when data_valid=1 and data_ready=1; on that edge the FSM SHALL load data_in into the shift register, set bit_cnt=0 and go to SHIFT.
REQ-017 In LOAD with data_valid=0, the FSM SHALL stall, holding the detector state and count unchanged.
REQ-018 In SHIFT, each cycle SHALL present shift-register bit 7 to the detector, shift left by one and increment bit_cnt.
REQ-019 A byte SHALL occupy exactly 8 SHIFT cycles; throughput SHALL be at most one byte per 9 cycles.
REQ-020 On the 8th SHIFT edge, the block SHALL decrement bytes_left, then go to LOAD if the result is greater than 0, else to DONE.
REQ-021 The embedded detector SHALL be an overlapping Moore "101" detector with states S0, S1, S2 and S3.
REQ-022 Detector transitions SHALL be: S0 goes to S1 on 1, else stays S0; S1 goes to S2 on 0, else stays S1; S2 goes to S3 on 1, else to S0; S3 goes to S1 on 1, else to S2.
REQ-023 The detector SHALL advance only during SHIFT cycles.
REQ-024 The detector state SHALL persist across byte boundaries within a frame, so patterns spanning two bytes are counted.
REQ-025 match_count SHALL increment on the same edge the detector enters S3 (S2 with bit=1), giving one increment per detection regardless of stalls.
REQ-026 match_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 DONE SHALL last exactly one cycle, with done=1 and busy=1, then go to IDLE.
REQ-028 match_count SHALL hold its final value from DONE until the next accepted start.
REQ-029 Outputs SHALL be registered or decoded from state only; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-030 When reset=1 at a clock edge, from any state including mid-byte or mid-stall, the block SHALL go to IDLE with detector S0, match_count=0, done=0, busy=0, data_ready=0, bytes_left=0 and bit_cnt=0.
REQ-031 reset SHALL take priority over start and over a data handshake on the same edge.

Verification
REQ-032 Single byte: start with frame_len=1, data 0xA5 accepted -> done pulses 9 cycles after the handshake edge, match_count=2.
REQ-033 Cross-byte: frame_len=2, data 0x02 then 0x80 -> match_count=1, where the pattern spans the byte boundary.
REQ-034 Stall plus overlap: frame_len=2, 0x55, data_valid low for 5 cycles, then 0x55 -> match_count=7, with no extra counts during the stall.
REQ-035 Saturation: frame_len=65, all bytes 0x55, CNT_W=8 -> match_count=255, held at 255 and not wrapped.
REQ-036 Zero length and ignored start: frame_len=0 -> done pulses the cycle after start with match_count=0; start pulses while busy have no effect.
REQ-037 Reset mid-SHIFT of byte 2 of 3 -> next edge IDLE with all outputs at reset values; a subsequent frame with 0xA5 gives match_count=2.

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: frame scanner that serializes bytes MSB-first into an overlapping "101" detector and counts hits
module seq_scan_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       frame_len,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
  localparam logic [1:0] S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3;
  logic [1:0] state, det, det_nxt;
  logic [7:0] sreg, bytes_left;
  logic [2:0] bit_cnt;
  logic b, hit;
  assign b = sreg[7];
  assign hit = (det == S2) && b;
  assign data_ready = state == LOAD;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb
    det_nxt = (det == S0) ? (b ? S1 : S0) :
              (det == S1) ? (b ? S1 : S2) :
              (det == S2) ? (b ? S3 : S0) :
                            (b ? S1 : S2);
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      det <= S0;
      match_count <= '0;
      bytes_left <= '0;
      bit_cnt <= '0;
      sreg <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        match_count <= '0;
        det <= S0;
        bytes_left <= frame_len;
        state <= (frame_len == 8'd0) ? DONE : LOAD;
      end
    end else if (state == LOAD) begin
      if (data_valid) begin
        sreg <= data_in;
        bit_cnt <= '0;
        state <= SHIFT;
      end
    end else if (state == SHIFT) begin
      det <= det_nxt;
      sreg <= {sreg[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
      if (hit && !(&match_count)) match_count <= match_count + 1'b1;
      if (bit_cnt == 3'd7) begin
        bytes_left <= bytes_left - 8'd1;
        state <= (bytes_left == 8'd1) ? DONE : LOAD;
      end
    end else
      state <= IDLE;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: directed and random frames checked against a sliding-window "101" count model
module tb_seq_scan_ctrl;
  logic clock = 0, reset = 1, start = 0, data_valid = 0;
  logic [7:0] frame_len = 0, data_in = 0;
  logic data_ready, busy, done;
  logic [7:0] match_count;
  logic [7:0] fb [0:255];
  int tests = 0, fails = 0;

  seq_scan_ctrl #(.CNT_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .frame_len(frame_len),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done), .match_count(match_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count every position where the last three serialized bits read 1,0,1, saturating at 255.
  function automatic int model(input int nbytes);
    int c = 0;
    logic [2:0] w = 3'b000;
    for (int i = 0; i < nbytes; i++)
      for (int k = 7; k >= 0; k--) begin
        w = {w[1:0], fb[i][k]};
        if (w == 3'b101) c++;
      end
    return (c > 255) ? 255 : c;
  endfunction

  // stall < 0 picks a random stall of 0..3 cycles before each byte
  task automatic frame(input int len, input int stall, input string tag);
    int s;
    @(negedge clock);
    start = 1;
    frame_len = len[7:0];
    @(negedge clock);
    start = 0;
    if (len == 0) begin
      chk({tag, " zero done"}, done, 1);
      chk({tag, " zero busy"}, busy, 1);
      chk({tag, " zero count"}, match_count, 0);
      @(negedge clock);
      chk({tag, " zero idle"}, {busy, done}, 0);
      return;
    end
    for (int i = 0; i < len; i++) begin
      s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int j = 0; j < s; j++) begin
        data_valid = 0;
        data_in = 8'($urandom);
        start = 1'($urandom);
        chk({tag, " stall ready"}, data_ready, 1);
        chk({tag, " stall count"}, match_count, model(i));
        @(negedge clock);
      end
      start = 1'($urandom);
      data_valid = 1;
      data_in = fb[i];
      chk({tag, " load ready"}, data_ready, 1);
      chk({tag, " load busy"}, busy, 1);
      @(negedge clock);
      data_valid = 0;
      data_in = 8'($urandom);
      for (int j = 0; j < 8; j++) begin
        start = 1'($urandom);
        chk({tag, " shift flags"}, {data_ready, done, busy}, 3'b001);
        @(negedge clock);
      end
    end
    start = 0;
    chk({tag, " done"}, {done, busy}, 2'b11);
    chk({tag, " count"}, match_count, model(len));
    @(negedge clock);
    chk({tag, " post idle"}, {busy, done, data_ready}, 0);
    chk({tag, " hold"}, match_count, model(len));
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset flags", {busy, done, data_ready}, 0);
    chk("reset count", match_count, 0);
    reset = 0;
    @(negedge clock);
    chk("idle hold", {busy, done}, 0);
    fb[0] = 8'hA5;
    frame(1, 0, "single_a5");
    fb[0] = 8'h02; fb[1] = 8'h80;
    frame(2, 1, "cross");
    fb[0] = 8'h55; fb[1] = 8'h55;
    frame(2, 5, "stall55");
    for (int i = 0; i < 65; i++) fb[i] = 8'h55;
    frame(65, 0, "sat");
    frame(0, 0, "zero");
    for (int i = 0; i < 3; i++) fb[i] = 8'($urandom);
    @(negedge clock);
    start = 1; frame_len = 3;
    @(negedge clock);
    start = 0; data_valid = 1; data_in = fb[0];
    @(negedge clock);
    data_valid = 0;
    repeat (8) @(negedge clock);
    data_valid = 1; data_in = fb[1];
    @(negedge clock);
    data_valid = 1; start = 1;
    repeat (3) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0; start = 0; data_valid = 0;
    chk("midreset flags", {busy, done, data_ready}, 0);
    chk("midreset count", match_count, 0);
    @(negedge clock);
    chk("midreset stays idle", busy, 0);
    fb[0] = 8'hA5;
    frame(1, 0, "after_reset");
    for (int n = 0; n < 12; n++) begin
      int len;
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
      frame(len, -1, "random");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
